fork_eager_tehb: RTL and testbench

- Elastic dataflow fork: one valid/ready input token is broadcast to OUTPUTS consumers.
- Each consumer receives the token exactly once. Each output branch is accepted independently ("eager"), so no branch waits for its siblings.
- A one-slot transparent elastic buffer (TEHB) sits in front of the fork. It cuts the combinational ready path from the consumers back to the producer.
- It sits at fan-out points of the elastic circuit, the mirror of a merge: many-to-one there, one-to-many here.

---
 rtl/fork_eager_tehb.sv | 96 +++++++++
 tb/tb_fork_eager_tehb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fork_eager_tehb.sv
// rtl/fork_eager_tehb.sv - eager elastic fork with a one-slot transparent buffer in front
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   ins, ins_valid  producer token and its valid
//   ins_ready       producer ready, driven from registered state only
//   outs            OUTPUTS copies of the token, branch i at [i*BITWIDTH +: BITWIDTH]
//   outs_valid      per-branch valid
//   outs_ready      per-branch ready
module fork_eager_tehb #(
    parameter int OUTPUTS  = 2,
    parameter int BITWIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BITWIDTH-1:0]          ins,
    input  logic                         ins_valid,
    output logic                         ins_ready,
    output logic [OUTPUTS*BITWIDTH-1:0]  outs,
    output logic [OUTPUTS-1:0]           outs_valid,
    input  logic [OUTPUTS-1:0]           outs_ready
);

    // Buffer slot state
    logic                full;
    logic [BITWIDTH-1:0] slot_data;

    // Branches that have already taken the current token
    logic [OUTPUTS-1:0]  sent;

    // Token presented to the fork stage
    logic [BITWIDTH-1:0] src_data;
    logic                src_valid;

    // Fork completion
    logic [OUTPUTS-1:0]  done;
    logic                fork_ready;

    // Slot control
    logic                capture;
    logic                drain;

    // ------------------------------------------------------------------
    // Buffer stage: transparent while empty, so a token that the fork
    // can finish immediately passes straight through with no latency.
    // ------------------------------------------------------------------
    assign ins_ready = ~full;
    assign src_data  = full ? slot_data : ins;
    assign src_valid = full | ins_valid;

    // A token is parked only if it arrives into an empty slot and at
    // least one branch fails to take it this cycle.
    assign capture = ~full & ins_valid & ~fork_ready;
    assign drain   = full & fork_ready;

    // ------------------------------------------------------------------
    // Eager fork stage
    // ------------------------------------------------------------------
    assign outs_valid = {OUTPUTS{src_valid}} & ~sent;
    assign outs       = {OUTPUTS{src_data}};

    // A branch is finished with the token if it took it earlier or is
    // taking it now; the token completes once every branch is finished.
    assign done       = sent | outs_ready;
    assign fork_ready = &done;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 1'b0;
            slot_data <= '0;
        end else if (capture) begin
            full      <= 1'b1;
            slot_data <= ins;
        end else if (drain) begin
            full      <= 1'b0;
        end
    end

    // sent stays zero whenever no token is presented, so it only needs
    // updating while src_valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent <= '0;
        end else if (src_valid) begin
            if (fork_ready) begin
                sent <= '0;
            end else begin
                sent <= sent | (outs_valid & outs_ready);
            end
        end
    end

endmodule

// File: tb/tb_fork_eager_tehb.sv
// tb/tb_fork_eager_tehb.sv - self-checking bench for fork_eager_tehb (3-branch and 1-branch instances)
module tb_fork_eager_tehb;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 3-branch instance
    logic [W-1:0]   ins3;
    logic           iv3;
    logic           ir3;
    logic [3*W-1:0] o3;
    logic [2:0]     ov3;
    logic [2:0]     or3;

    // 1-branch instance
    logic [W-1:0]   ins1;
    logic           iv1;
    logic           ir1;
    logic [W-1:0]   o1;
    logic [0:0]     ov1;
    logic [0:0]     or1;

    fork_eager_tehb #(.OUTPUTS(3), .BITWIDTH(W)) dut3 (
        .clk(clk), .rst(rst),
        .ins(ins3), .ins_valid(iv3), .ins_ready(ir3),
        .outs(o3), .outs_valid(ov3), .outs_ready(or3)
    );

    fork_eager_tehb #(.OUTPUTS(1), .BITWIDTH(W)) dut1 (
        .clk(clk), .rst(rst),
        .ins(ins1), .ins_valid(iv1), .ins_ready(ir1),
        .outs(o1), .outs_valid(ov1), .outs_ready(or1)
    );

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;
    bit drive1   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every branch owns a FIFO of tokens it is still owed.
    // The producer can hand over a token only when nothing is owed anywhere;
    // a token on offer with nothing owed is visible on every branch.
    logic [W-1:0] q3 [3][$];
    logic [W-1:0] q1 [$];
    int cnt3 [3];
    int acc3;
    int cnt1;
    int acc1;

    always @(negedge clk) begin
        bit           empty3;
        bit           empty1;
        logic [W-1:0] ed3;
        logic [W-1:0] ed1;
        logic [2:0]   ev3;
        logic         ev1;
        if (checking) begin
            empty3 = 1'b1;
            ed3    = ins3;
            for (int i = 2; i >= 0; i--) begin
                if (q3[i].size() != 0) begin
                    empty3 = 1'b0;
                    ed3    = q3[i][0];
                end
            end
            for (int i = 0; i < 3; i++) ev3[i] = (q3[i].size() != 0) || (empty3 && iv3);
            chk("m3_ins_ready", ir3, empty3);
            chk("m3_outs_valid", ov3, ev3);
            for (int i = 0; i < 3; i++) chk($sformatf("m3_outs%0d", i), o3[i*W +: W], ed3);

            empty1 = (q1.size() == 0);
            ed1    = empty1 ? ins1 : q1[0];
            ev1    = !empty1 || iv1;
            chk("m1_ins_ready", ir1, empty1);
            chk("m1_outs_valid", ov1, ev1);
            chk("m1_outs", o1, ed1);

            if (rst) begin
                for (int i = 0; i < 3; i++) begin
                    q3[i].delete();
                    cnt3[i] = 0;
                end
                q1.delete();
                acc3 = 0;
                acc1 = 0;
                cnt1 = 0;
            end else begin
                if (iv3 && ir3) acc3++;
                for (int i = 0; i < 3; i++) if (ov3[i] && or3[i]) cnt3[i]++;
                if (iv1 && ir1) acc1++;
                if (ov1[0] && or1[0]) cnt1++;

                if (iv3 && empty3) for (int i = 0; i < 3; i++) q3[i].push_back(ins3);
                for (int i = 0; i < 3; i++) if (ev3[i] && or3[i]) void'(q3[i].pop_front());
                if (iv1 && empty1) q1.push_back(ins1);
                if (ev1 && or1[0]) void'(q1.pop_front());
            end
        end
    end

    // Random driver for the 1-branch instance; also wiggles outs_ready
    // mid-cycle to confirm ins_ready does not follow it.
    always @(posedge clk) begin
        logic snap;
        #1;
        if (drive1) begin
            ins1 = W'($urandom);
            iv1  = 1'($urandom_range(0, 1));
            or1  = 1'($urandom_range(0, 1));
            #1;
            snap = ir1;
            or1  = ~or1;
            #1;
            chk("m1_ready_comb", ir1, snap);
            or1  = ~or1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        #2;
    endtask

    initial begin
        rst  = 1'b1;
        ins3 = '0; iv3 = 1'b0; or3 = '0;
        ins1 = '0; iv1 = 1'b0; or1 = '0;
        for (int i = 0; i < 3; i++) cnt3[i] = 0;
        acc3 = 0; acc1 = 0; cnt1 = 0;
        tick;
        tick;
        rst = 1'b0;
        checking = 1'b1;
        drive1   = 1'b1;
        ins3 = 8'h42;
        look;
        chk("reset_ins_ready", ir3, 1'b1);
        chk("reset_outs_valid", ov3, 3'b000);
        chk("reset_outs", o3, 24'h424242);
        tick;

        // All branches ready: one token per cycle, bypass
        or3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            ins3 = 8'h11 + 8'(k);
            iv3  = 1'b1;
            look;
            chk("bypass_valid", ov3, 3'b111);
            chk("bypass_data", o3, {3{ins3}});
            chk("bypass_ready", ir3, 1'b1);
            tick;
        end
        iv3 = 1'b0;
        look;
        for (int i = 0; i < 3; i++) chk("bypass_count", 64'(cnt3[i]), 64'd4);

        // Partial acceptance
        tick;
        or3 = 3'b101; ins3 = 8'hA5; iv3 = 1'b1;
        look;
        chk("partial_c0_valid", ov3, 3'b111);
        tick;
        iv3 = 1'b0; ins3 = 8'h5A;
        for (int c = 1; c <= 2; c++) begin
            look;
            chk("partial_ready", ir3, 1'b0);
            chk("partial_valid", ov3, 3'b010);
            chk("partial_data1", o3[15:8], 8'hA5);
            chk("partial_data0", o3[7:0], 8'hA5);
            tick;
        end
        or3 = 3'b111;
        look;
        chk("partial_c3_valid", ov3, 3'b010);
        tick;
        look;
        chk("partial_c4_ready", ir3, 1'b1);
        chk("partial_c4_valid", ov3, 3'b000);
        for (int i = 0; i < 3; i++) chk("partial_count", 64'(cnt3[i]), 64'd5);

        // Staggered readies
        tick;
        ins3 = 8'h3C; iv3 = 1'b1; or3 = 3'b001;
        look;
        chk("stagger_c0_valid", ov3, 3'b111);
        tick;
        iv3 = 1'b0; ins3 = 8'hFF; or3 = 3'b010;
        look;
        chk("stagger_c1_valid", ov3, 3'b110);
        chk("stagger_c1_data", o3, 24'h3C3C3C);
        tick;
        or3 = 3'b100;
        look;
        chk("stagger_c2_valid", ov3, 3'b100);
        chk("stagger_c2_data", o3, 24'h3C3C3C);
        tick;
        look;
        chk("stagger_done_ready", ir3, 1'b1);
        for (int i = 0; i < 3; i++) chk("stagger_count", 64'(cnt3[i]), 64'd6);

        // Back-to-back with a stall on branch 1
        tick;
        ins3 = 8'h01; iv3 = 1'b1; or3 = 3'b101;
        tick;
        ins3 = 8'h02;
        for (int c = 0; c < 5; c++) begin
            look;
            chk("b2b_stall_ready", ir3, 1'b0);
            chk("b2b_stall_data", o3[15:8], 8'h01);
            tick;
        end
        or3 = 3'b111;
        look;
        chk("b2b_last_ready", ir3, 1'b0);
        tick;
        look;
        chk("b2b_next_valid", ov3, 3'b111);
        chk("b2b_next_data", o3, 24'h020202);
        tick;
        iv3 = 1'b0;
        look;
        for (int i = 0; i < 3; i++) chk("b2b_count", 64'(cnt3[i]), 64'd8);

        // Reset mid-token
        tick;
        ins3 = 8'h77; iv3 = 1'b1; or3 = 3'b001;
        tick;
        iv3 = 1'b0; or3 = 3'b000;
        look;
        chk("rst_partial_valid", ov3, 3'b110);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0; or3 = 3'b111;
        look;
        chk("rst_ready", ir3, 1'b1);
        chk("rst_valid", ov3, 3'b000);
        tick;
        tick;
        look;
        for (int i = 0; i < 3; i++) chk("rst_no_redeliver", 64'(cnt3[i]), 64'd0);

        // Random traffic on the 3-branch instance
        for (int c = 0; c < 1000; c++) begin
            tick;
            ins3 = W'($urandom);
            iv3  = 1'($urandom_range(0, 1));
            or3  = 3'($urandom);
        end

        // Drain both instances and check conservation
        drive1 = 1'b0;
        tick;
        iv3 = 1'b0; or3 = 3'b111;
        iv1 = 1'b0; or1 = 1'b1;
        tick;
        tick;
        look;
        chk("drain3_valid", ov3, 3'b000);
        chk("drain3_ready", ir3, 1'b1);
        chk("drain1_valid", ov1, 1'b0);
        chk("drain1_ready", ir1, 1'b1);
        for (int i = 0; i < 3; i++) chk("conserve3", 64'(cnt3[i]), 64'(acc3));
        chk("conserve1", 64'(cnt1), 64'(acc1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
